// File: rtl/types_pkg.sv
// Shared types for the memory stage: LSU state encoding, RV32I funct3 codes,
// bus request payload and small size/alignment helpers.
package types_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned BeW   = WordW / 8;

  typedef logic [WordW-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef struct packed {
    word_t          addr;
    word_t          wdata;
    logic [BeW-1:0] be;
    logic           we;
    logic [2:0]     funct3;
  } lsu_req_t;

  // Undefined funct3 encodings fall through to a full-word access.
  function automatic logic [1:0] accessSize(input logic [2:0] f3);
    case (f3[1:0])
      F3_SB[1:0]: accessSize = SzByte;
      F3_SH[1:0]: accessSize = SzHalf;
      default:    accessSize = SzWord;
    endcase
  endfunction

  function automatic logic isAligned(input logic [2:0] f3, input logic [1:0] off);
    case (accessSize(f3))
      SzByte:  isAligned = 1'b1;
      SzHalf:  isAligned = ~off[0];
      default: isAligned = (off == 2'b00);
    endcase
  endfunction

  function automatic logic [BeW-1:0] byteEnable(input logic [2:0] f3, input logic [1:0] off);
    case (accessSize(f3))
      SzByte:  byteEnable = BeW'(4'b0001 << off);
      SzHalf:  byteEnable = BeW'(4'b0011 << off);
      default: byteEnable = {BeW{1'b1}};
    endcase
  endfunction

  function automatic word_t storeData(input logic [2:0] f3, input word_t wd);
    case (accessSize(f3))
      SzByte:  storeData = {4{wd[7:0]}};
      SzHalf:  storeData = {2{wd[15:0]}};
      default: storeData = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and sign/zero-extends it.
module load_align
  import types_pkg::*;
(
  input  logic [WordW-1:0] dmem_rdata,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  output logic [WordW-1:0] dataOut
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8  = 8'(dmem_rdata >> {offset, 3'b000});
    lane16 = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      F3_LB:   dataOut = {{(WordW-8){lane8[7]}}, lane8};
      F3_LH:   dataOut = {{(WordW-16){lane16[15]}}, lane16};
      F3_LBU:  dataOut = {{(WordW-8){1'b0}}, lane8};
      F3_LHU:  dataOut = {{(WordW-16){1'b0}}, lane16};
      default: dataOut = dmem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: valid/ready data bus master with pipeline stall.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_access_unit
  import types_pkg::*;
#(
  parameter int unsigned XLEN           = WordW,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            MisalignedM,
  output logic            BusErrorM,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata
);

`ifdef LSU_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e      stateQ, stateNext;
  lsu_req_t        reqQ, reqNew;
  logic            accessM, alignedM, startAccess, abort, timeoutHit;
  logic [CntW-1:0] timeoutCnt;
  word_t           alignedData;

  // Decode the M-stage access into a bus request; both strobes high means store.
  always_comb begin
    accessM  = MemReadM | MemWriteM;
    alignedM = isAligned(Funct3M, ALUResultM[1:0]);
    reqNew   = '{addr:   ALUResultM,
                 wdata:  storeData(Funct3M, WriteDataM),
                 be:     byteEnable(Funct3M, ALUResultM[1:0]),
                 we:     MemWriteM,
                 funct3: Funct3M};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateNext;
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:     if (accessM && alignedM) stateNext = REQ;
      REQ: begin
        if (dmem_req_ready)  stateNext = reqQ.we ? DONE : WAIT_RSP;
        else if (timeoutHit) stateNext = DONE;
      end
      WAIT_RSP: if (dmem_rsp_valid || timeoutHit) stateNext = DONE;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Stall and misalign flags respond in the same cycle the access is presented.
  always_comb begin
    StallM      = 1'b0;
    MisalignedM = 1'b0;
    startAccess = 1'b0;
    abort       = 1'b0;
    case (stateQ)
      IDLE: begin
        startAccess = accessM && alignedM;
        StallM      = startAccess;
        MisalignedM = accessM && !alignedM;
      end
      REQ: begin
        StallM = 1'b1;
        abort  = timeoutHit && !dmem_req_ready;
      end
      WAIT_RSP: begin
        StallM = 1'b1;
        abort  = timeoutHit && !dmem_rsp_valid;
      end
      default: ;
    endcase
    if (!reset) begin
      StallM      = 1'b0;
      MisalignedM = 1'b0;
    end
  end

  // Watchdog restarts from zero whenever a waiting state is (re)entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timeoutCnt <= '0;
    else if ((stateNext != stateQ) || !((stateQ == REQ) || (stateQ == WAIT_RSP)))
      timeoutCnt <= '0;
    else
      timeoutCnt <= timeoutCnt + 1'b1;
  end

  assign timeoutHit = TimeoutEn && (timeoutCnt == CntW'(TIMEOUT_CYCLES));

  load_align u_load_align (
    .dmem_rdata (dmem_rdata),
    .offset     (reqQ.addr[1:0]),
    .funct3     (reqQ.funct3),
    .dataOut    (alignedData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqQ           <= '0;
      dmem_req_valid <= 1'b0;
      ReadDataM      <= '0;
      BusErrorM      <= 1'b0;
    end else begin
      if (startAccess) reqQ <= reqNew;
      dmem_req_valid <= (stateNext == REQ);
      BusErrorM      <= abort;
      if ((stateQ == WAIT_RSP) && dmem_rsp_valid) ReadDataM <= alignedData;
      else if (abort)                             ReadDataM <= '0;
    end
  end

  assign dmem_addr  = {reqQ.addr[XLEN-1:2], 2'b00};
  assign dmem_we    = reqQ.we;
  assign dmem_wdata = reqQ.wdata;
  assign dmem_be    = reqQ.be;

endmodule
